// File: rtl/tcm_port_arbiter.sv
// tcm_port_arbiter
//   Shares one port of the TCM scratchpad SRAM between two requesters:
//   M0 (core data path) and M1 (boot-loader / DMA path). Grants are round-robin
//   with one outstanding access at a time. All memory-side outputs are registered.
//   The wait on the SRAM ready is bounded, and an expired wait completes the
//   access with an error response.
//
// Ports
//   clk_i, rst_i               clock, asynchronous active-high reset
//   mN_req_i                   request, held until the matching mN_ready_o
//   mN_we_i/be_i/addr_i/data_i access attributes (1 = write)
//   mN_data_o                  read data, valid while mN_ready_o is high
//   mN_ready_o                 one-cycle completion pulse
//   mN_err_o                   timeout flag, only together with mN_ready_o
//   mem_en_o/we_o/be_o/addr_o/data_o  SRAM port request
//   mem_data_i, mem_ready_i    SRAM response (ready one cycle after enable)
//   grant_o                    current or most recent grant (0 = M0, 1 = M1)
module tcm_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_ENTRIES  = 1024,
  parameter int unsigned TIMEOUT    = 15,
  localparam int unsigned AW = $clog2(N_ENTRIES),
  localparam int unsigned BW = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  m0_req_i,
  input  logic                  m0_we_i,
  input  logic [BW-1:0]         m0_be_i,
  input  logic [AW-1:0]         m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  output logic                  m0_ready_o,
  output logic                  m0_err_o,

  input  logic                  m1_req_i,
  input  logic                  m1_we_i,
  input  logic [BW-1:0]         m1_be_i,
  input  logic [AW-1:0]         m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic                  m1_ready_o,
  output logic                  m1_err_o,

  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [BW-1:0]         mem_be_o,
  output logic [AW-1:0]         mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  mem_ready_i,

  output logic                  grant_o
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait} state_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  state_e                state_q;
  logic [7:0]            cnt_q;
  logic                  rd_q;      // in-flight access is a read
  logic                  grant_q;

  logic                  mem_en_q;
  logic                  mem_we_q;
  logic [BW-1:0]         mem_be_q;
  logic [AW-1:0]         mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_data_q;

  logic [DATA_WIDTH-1:0] m0_data_q;
  logic                  m0_ready_q;
  logic                  m0_err_q;
  logic [DATA_WIDTH-1:0] m1_data_q;
  logic                  m1_ready_q;
  logic                  m1_err_q;

  logic                  elig0;
  logic                  elig1;
  logic                  sel;

  // A requester still holding req during its own completion pulse is not
  // eligible, so it cannot be re-granted for an access it already finished.
  assign elig0 = m0_req_i & ~m0_ready_q;
  assign elig1 = m1_req_i & ~m1_ready_q;
  // On contention the master that did not win last time goes next.
  assign sel   = (elig0 & elig1) ? ~grant_q : elig1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rd_q       <= 1'b0;
      grant_q    <= 1'b1;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_be_q   <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      m0_data_q  <= '0;
      m0_ready_q <= 1'b0;
      m0_err_q   <= 1'b0;
      m1_data_q  <= '0;
      m1_ready_q <= 1'b0;
      m1_err_q   <= 1'b0;
    end else begin
      // Completion flags are single-cycle pulses.
      m0_ready_q <= 1'b0;
      m0_err_q   <= 1'b0;
      m1_ready_q <= 1'b0;
      m1_err_q   <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (elig0 | elig1) begin
            grant_q    <= sel;
            mem_en_q   <= 1'b1;
            mem_we_q   <= sel ? m1_we_i   : m0_we_i;
            rd_q       <= sel ? ~m1_we_i  : ~m0_we_i;
            mem_be_q   <= sel ? m1_be_i   : m0_be_i;
            mem_addr_q <= sel ? m1_addr_i : m0_addr_i;
            mem_data_q <= sel ? m1_data_i : m0_data_i;
            state_q    <= StAccess;
          end
        end

        StAccess: begin
          // Address, byte enables and data stay put until the next grant.
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          cnt_q    <= '0;
          state_q  <= StWait;
        end

        StWait: begin
          if (mem_ready_i) begin
            // Ready wins over a coincident timeout.
            if (grant_q) begin
              m1_ready_q <= 1'b1;
              if (rd_q) m1_data_q <= mem_data_i;
            end else begin
              m0_ready_q <= 1'b1;
              if (rd_q) m0_data_q <= mem_data_i;
            end
            state_q <= StIdle;
          end else if (cnt_q + 8'd1 == TimeoutCnt) begin
            if (grant_q) begin
              m1_ready_q <= 1'b1;
              m1_err_q   <= 1'b1;
            end else begin
              m0_ready_q <= 1'b1;
              m0_err_q   <= 1'b1;
            end
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign m0_data_o  = m0_data_q;
  assign m0_ready_o = m0_ready_q;
  assign m0_err_o   = m0_err_q;
  assign m1_data_o  = m1_data_q;
  assign m1_ready_o = m1_ready_q;
  assign m1_err_o   = m1_err_q;
  assign mem_en_o   = mem_en_q;
  assign mem_we_o   = mem_we_q;
  assign mem_be_o   = mem_be_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign grant_o    = grant_q;

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Self-checking bench for tcm_port_arbiter: a table of single transactions
// plus hand-written sequences for round-robin, hold-through, timeout and
// reset during an access. A behavioural SRAM answers one cycle after enable.
module tb_tcm_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int BW = 4;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [BW-1:0] m0_be, m1_be;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wd, m1_wd;
  logic [DW-1:0] m0_data_o, m1_data_o;
  logic          m0_ready_o, m0_err_o, m1_ready_o, m1_err_o;
  logic          mem_en_o, mem_we_o;
  logic [BW-1:0] mem_be_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic [DW-1:0] mem_rd;
  logic          mem_rdy;
  logic          grant_o;
  logic          mute;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_d [2];

  always #5 clk = ~clk;

  tcm_port_arbiter #(.DATA_WIDTH(DW), .N_ENTRIES(1024), .TIMEOUT(TO)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .m0_req_i   (m0_req),
    .m0_we_i    (m0_we),
    .m0_be_i    (m0_be),
    .m0_addr_i  (m0_addr),
    .m0_data_i  (m0_wd),
    .m0_data_o  (m0_data_o),
    .m0_ready_o (m0_ready_o),
    .m0_err_o   (m0_err_o),
    .m1_req_i   (m1_req),
    .m1_we_i    (m1_we),
    .m1_be_i    (m1_be),
    .m1_addr_i  (m1_addr),
    .m1_data_i  (m1_wd),
    .m1_data_o  (m1_data_o),
    .m1_ready_o (m1_ready_o),
    .m1_err_o   (m1_err_o),
    .mem_en_o   (mem_en_o),
    .mem_we_o   (mem_we_o),
    .mem_be_o   (mem_be_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_data_i (mem_rd),
    .mem_ready_i(mem_rdy),
    .grant_o    (grant_o)
  );

  // Behavioural SRAM; contents reload from presets while reset is high.
  logic [DW-1:0] sram [1024];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) sram[i] <= '0;
      sram[10'h010] <= 32'hDEADBEEF;
      sram[10'h3FF] <= 32'hAABBCCDD;
      sram[10'h020] <= 32'h20202020;
      sram[10'h021] <= 32'h21212121;
      sram[10'h0AA] <= 32'h5555AAAA;
      mem_rdy <= 1'b0;
      mem_rd  <= '0;
    end else begin
      mem_rdy <= mem_en_o & ~mute;
      if (mem_en_o) begin
        if (mem_we_o) begin
          for (int b = 0; b < BW; b++)
            if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_data_o[8*b +: 8];
        end else begin
          mem_rd <= sram[mem_addr_o];
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int m, input logic req, input logic we, input logic [3:0] be,
                       input logic [9:0] addr, input logic [31:0] wd);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_be = be; m0_addr = addr; m0_wd = wd;
    end else begin
      m1_req = req; m1_we = we; m1_be = be; m1_addr = addr; m1_wd = wd;
    end
  endtask

  // One isolated transaction; called right after a posedge (+1).
  task automatic txn(input int m, input logic we, input logic [3:0] be, input logic [9:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                     input int exp_lat, input string tag);
    int   cyc, en_cnt, en_cyc, oth;
    logic got, rdy, err;
    cyc = 0; en_cnt = 0; en_cyc = -1; oth = 0; got = 1'b0; err = 1'b0;
    drive(m, 1'b1, we, be, addr, wd);
    while (!got && cyc < 40) begin
      @(negedge clk);
      if (mem_en_o) begin
        en_cnt++;
        en_cyc = cyc;
        chk({tag, " mem_addr"}, 32'(mem_addr_o), 32'(addr));
        chk({tag, " mem_we"}, 32'(mem_we_o), 32'(we));
        chk({tag, " grant"}, 32'(grant_o), m);
        if (we) begin
          chk({tag, " mem_be"}, 32'(mem_be_o), 32'(be));
          chk({tag, " mem_data"}, mem_data_o, wd);
        end
      end
      if ((m == 0) ? m1_ready_o : m0_ready_o) oth++;
      rdy = (m == 0) ? m0_ready_o : m1_ready_o;
      if (rdy) begin
        got = 1'b1;
        err = (m == 0) ? m0_err_o : m1_err_o;
      end else begin
        cyc++;
      end
    end
    chk({tag, " latency"}, cyc, exp_lat);
    chk({tag, " err"}, 32'(err), 32'(exp_err));
    chk({tag, " en count"}, en_cnt, 1);
    chk({tag, " en cycle"}, en_cyc, 1);
    chk({tag, " other ready"}, oth, 0);
    if (!we && !exp_err) exp_d[m] = exp_rd;
    chk({tag, " m0_data"}, m0_data_o, exp_d[0]);
    chk({tag, " m1_data"}, m1_data_o, exp_d[1]);
    @(posedge clk); #1;
    drive(m, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    @(negedge clk);
    chk({tag, " ready pulse width"}, 32'((m == 0) ? m0_ready_o : m1_ready_o), 32'd0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    int          m;
    logic        we;
    logic [3:0]  be;
    logic [9:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [7];
  int   order [8];

  initial begin
    int   n, dbl, both, en_cnt, en1, en2, rdy1, first_m, first_cyc, m1_cyc, stale;
    logic prev_r, m0_done, m1_done, first_seen;

    vecs[0] = '{m: 0, we: 1'b0, be: 4'h0, addr: 10'h010, wd: 32'h0,        exp_rd: 32'hDEADBEEF};
    vecs[1] = '{m: 1, we: 1'b1, be: 4'h5, addr: 10'h3FF, wd: 32'h11223344, exp_rd: 32'h0};
    vecs[2] = '{m: 0, we: 1'b0, be: 4'h0, addr: 10'h3FF, wd: 32'h0,        exp_rd: 32'hAA22CC44};
    vecs[3] = '{m: 0, we: 1'b1, be: 4'hF, addr: 10'h000, wd: 32'h01234567, exp_rd: 32'h0};
    vecs[4] = '{m: 1, we: 1'b0, be: 4'h0, addr: 10'h000, wd: 32'h0,        exp_rd: 32'h01234567};
    vecs[5] = '{m: 1, we: 1'b1, be: 4'h8, addr: 10'h155, wd: 32'hFF000000, exp_rd: 32'h0};
    vecs[6] = '{m: 0, we: 1'b0, be: 4'h0, addr: 10'h155, wd: 32'h0,        exp_rd: 32'hFF000000};

    mute = 1'b0;
    rst  = 1'b1;
    drive(0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    exp_d[0] = '0;
    exp_d[1] = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst mem_en", 32'(mem_en_o), 0);
    chk("rst mem_addr", 32'(mem_addr_o), 0);
    chk("rst ready", 32'({m0_ready_o, m1_ready_o, m0_err_o, m1_err_o}), 0);
    chk("rst data", m0_data_o | m1_data_o, 0);
    chk("rst grant", 32'(grant_o), 1);

    // Round-robin from reset with both requests held.
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 4'h0, 10'h020, 32'h0);
    drive(1, 1'b1, 1'b0, 4'h0, 10'h021, 32'h0);
    n = 0; dbl = 0; both = 0; en_cnt = 0; prev_r = 1'b0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      @(negedge clk);
      if (mem_en_o) en_cnt++;
      if (m0_ready_o && m1_ready_o) both++;
      if ((m0_ready_o || m1_ready_o) && prev_r) dbl++;
      if (m0_ready_o && n < 8) begin
        order[n] = 0; n++;
        chk("rr m0_data", m0_data_o, 32'h20202020);
      end
      if (m1_ready_o && n < 8) begin
        order[n] = 1; n++;
        chk("rr m1_data", m1_data_o, 32'h21212121);
      end
      prev_r = m0_ready_o | m1_ready_o;
    end
    chk("rr count", n, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("rr order %0d", i), order[i], i % 2);
    chk("rr double pulse", dbl, 0);
    chk("rr both ready", both, 0);
    chk("rr en count", en_cnt, 6);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    repeat (6) @(posedge clk);
    #1;
    exp_d[0] = 32'h20202020;
    exp_d[1] = 32'h21212121;

    // Table of isolated transactions.
    for (int k = 0; k < 7; k++)
      txn(vecs[k].m, vecs[k].we, vecs[k].be, vecs[k].addr, vecs[k].wd, vecs[k].exp_rd, 1'b0, 3,
          $sformatf("v%0d", k));

    // M0 holds req through its ready pulse: grants 4 cycles apart.
    drive(0, 1'b1, 1'b0, 4'h0, 10'h010, 32'h0);
    en1 = -1; en2 = -1; rdy1 = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mem_en_o) begin
        if (en1 < 0) en1 = c;
        else if (en2 < 0) en2 = c;
      end
      if (m0_ready_o && rdy1 < 0) rdy1 = c;
    end
    chk("hold en1", en1, 1);
    chk("hold ready1", rdy1, 3);
    chk("hold en2", en2, 5);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    exp_d[0] = 32'hDEADBEEF;
    chk("hold m0_data", m0_data_o, exp_d[0]);

    // Timeout on M0, then a clean M1 access.
    mute = 1'b1;
    txn(0, 1'b0, 4'h0, 10'h3FF, 32'h0, 32'h0, 1'b1, 2 + TO, "timeout");
    mute = 1'b0;
    txn(1, 1'b0, 4'h0, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0, 3, "after timeout");

    // Reset in the middle of an M1 WAIT.
    mute = 1'b1;
    drive(1, 1'b1, 1'b0, 4'h0, 10'h0AA, 32'h0);
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid rst mem_en", 32'(mem_en_o), 0);
    chk("mid rst mem_addr", 32'(mem_addr_o), 0);
    chk("mid rst data", m0_data_o | m1_data_o, 0);
    chk("mid rst ready", 32'({m0_ready_o, m1_ready_o, m0_err_o, m1_err_o}), 0);
    chk("mid rst grant", 32'(grant_o), 1);
    drive(0, 1'b1, 1'b0, 4'h0, 10'h010, 32'h0);
    mute = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m0_done = 1'b0; m1_done = 1'b0; first_seen = 1'b0;
    first_m = -1; first_cyc = -1; m1_cyc = -1; stale = 0;
    for (int c = 0; c < 20 && !m1_done; c++) begin
      @(negedge clk);
      if (mem_en_o && !first_seen) begin
        first_seen = 1'b1;
        chk("post rst first grant", 32'(grant_o), 0);
      end
      if (c < 3 && (m0_ready_o || m1_ready_o || m0_err_o || m1_err_o)) stale++;
      if (m0_ready_o && first_m < 0) begin first_m = 0; first_cyc = c; end
      if (m1_ready_o && first_m < 0) begin first_m = 1; first_cyc = c; end
      if (m0_ready_o) m0_done = 1'b1;
      if (m1_ready_o) begin
        m1_done = 1'b1;
        m1_cyc = c;
        chk("post rst m1_data", m1_data_o, 32'h5555AAAA);
        chk("post rst m1_err", 32'(m1_err_o), 0);
      end
      @(posedge clk); #1;
      if (m0_done) m0_req = 1'b0;
    end
    m1_req = 1'b0;
    chk("post rst stale ready", stale, 0);
    chk("post rst first master", first_m, 0);
    chk("post rst first cycle", first_cyc, 3);
    chk("post rst m1 cycle", m1_cyc, 6);
    chk("post rst m0_data", m0_data_o, 32'hDEADBEEF);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
